lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32, legal 32|64: data bus width; OB = log2(DW/8) byte-offset bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, legal 1..65535: max cycles awaiting ack.
REQ-004 SHALL have ports: i_clk in 1, sole clock (rising edge); i_rst in 1, synchronous active-high reset.
REQ-005 SHALL have ports: i_clk_en in 1, global advance enable; i_stall in 1, blocks new request acceptance.
REQ-006 SHALL have ports: i_valid in 1, request; i_store in 1, 1=store 0=load; i_size in 2, 0=byte 1=half 2=word 3=double (DW=64 only); i_unsigned in 1, zero-extend load.
REQ-007 SHALL have ports: i_rs1 in DW, base; i_imm in 32, offset; i_rs2 in DW, store data.
REQ-008 SHALL have ports: o_busy out 1; o_rd_write out 1, load result strobe; o_rd out DW, load result; o_misaligned out 1; o_bus_err out 1.
REQ-009 SHALL have read port: o_lsu_read out 1; o_r_lsu_addr out AW; i_r_lsu_data in DW; i_lsu_ack in 1, shared ack for read and write.
REQ-010 SHALL have write port: o_lsu_write out 1; o_w_lsu_addr out AW; o_w_lsu_byte_en out DW/8; o_w_lsu_data out DW.

Function
REQ-011 States: IDLE, RD_WAIT, WR_WAIT; o_busy = (state != IDLE).
REQ-012 When i_clk_en=0, all state, counters and outputs SHALL hold; strobes hold their value, not re-pulse.
REQ-013 Acceptance: IDLE & i_valid & i_clk_en & !i_stall; i_valid in any other condition ignored, no effect.
REQ-014 Effective address EA = i_rs1 + sign-extended i_imm, truncated to AW, modulo 2^AW (wrap, no flag).
REQ-015 Bus addresses SHALL be EA with low OB bits zeroed; both address outputs registered at acceptance, stable until return to IDLE.
REQ-016 Store: byte_en = ((1<<(1<<i_size))-1) << EA[OB-1:0]; data = i_rs2 low (8<<i_size) bits replicated across all lanes.
REQ-017 Accepted load: next cycle o_lsu_read=1, state RD_WAIT; accepted store: o_lsu_write=1, state WR_WAIT.
REQ-018 Strobe SHALL stay high until the cycle i_lsu_ack=1 (ack same cycle as strobe rise allowed); then strobe low, state IDLE next cycle.
REQ-019 Load ack: o_rd = lane at EA offset, size-masked, sign- or zero-extended per captured i_unsigned; o_rd_write=1 for exactly one cycle after ack; o_rd holds until next load completion.
REQ-020 i_size, i_unsigned, offset SHALL be captured at acceptance; later input changes ignored.
REQ-021 Timeout counter clears at acceptance, increments each enabled wait cycle; reaching TIMEOUT without ack: strobe low, o_bus_err one-cycle pulse, no o_rd_write, state IDLE.
REQ-022 Ack and timeout in same cycle: ack wins, no o_bus_err.
REQ-023 i_lsu_ack while IDLE ignored; i_stall while in a WAIT state does not abort.
REQ-024 i_size=3 with DW=32 treated as word.

Reset
REQ-025 i_rst (sync, overrides i_clk_en) SHALL force IDLE, counter 0, and all outputs 0, including o_rd.
REQ-026 Reset mid-transaction SHALL drop strobe next edge; a subsequent ack is ignored and produces no o_rd_write.

Configuration
REQ-027 Macro LSU_MISALIGN_TRAP_EN: defined -> access with EA not aligned to its size is not issued; o_misaligned one-cycle pulse the cycle after acceptance, state stays IDLE, no strobe.
REQ-028 Undefined -> o_misaligned tied 0; EA low log2 size bits forced to 0 (aligned down) before lane/byte_en computation.

Verification
REQ-029 DW=32, load byte rs1=0x1000, imm=0x3, bus data 0x80FF_0000, ack after 2 cycles -> o_r_lsu_addr=0x1000, o_rd=0xFFFF_FF80, o_rd_write 1 cycle.
REQ-030 Store half rs1=0x2002, imm=0, rs2=0x1234_ABCD, ack immediate -> byte_en=4'b1100, data=0xABCD_ABCD, o_rd_write stays 0.
REQ-031 TIMEOUT=4, load, no ack -> o_lsu_read high 4 cycles, then o_bus_err pulse, o_busy 0; late ack ignored.
REQ-032 Macro defined, load word EA=0x1001 -> o_misaligned pulse, o_lsu_read never asserts; macro undefined -> read issued at 0x1000.
REQ-033 i_clk_en low 3 cycles mid RD_WAIT, ack arrives while disabled then removed -> no completion; re-enable with ack -> single o_rd_write.
REQ-034 Reset asserted during WR_WAIT -> o_lsu_write 0 next cycle, all outputs 0; i_stall=1 with i_valid -> no acceptance.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: computes the effective address, issues one bus read or write, waits for ack or timeout.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with an o_misaligned pulse instead of aligning them down.
module lsu_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    input  logic            i_stall,
    input  logic            i_valid,
    input  logic            i_store,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    input  logic [DW-1:0]   i_rs1,
    input  logic [31:0]     i_imm,
    input  logic [DW-1:0]   i_rs2,
    output logic            o_busy,
    output logic            o_rd_write,
    output logic [DW-1:0]   o_rd,
    output logic            o_misaligned,
    output logic            o_bus_err,
    output logic            o_lsu_read,
    output logic [AW-1:0]   o_r_lsu_addr,
    input  logic [DW-1:0]   i_r_lsu_data,
    input  logic            i_lsu_ack,
    output logic            o_lsu_write,
    output logic [AW-1:0]   o_w_lsu_addr,
    output logic [DW/8-1:0] o_w_lsu_byte_en,
    output logic [DW-1:0]   o_w_lsu_data
);

    localparam int BW = DW / 8;
    localparam int OB = $clog2(BW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam logic [16:0] TO_L = 17'(TIMEOUT);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    function automatic logic [OB-1:0] size_mask(input logic [1:0] sz);
        logic [OB-1:0] m;
        case (sz)
            2'd0:    m = OB'(3'd0);
            2'd1:    m = OB'(3'd1);
            2'd2:    m = OB'(3'd3);
            default: m = OB'(3'd7);
        endcase
        return m;
    endfunction

    function automatic logic [BW-1:0] be_base(input logic [1:0] sz);
        logic [BW-1:0] b;
        for (int i = 0; i < BW; i++) begin
            b[i] = (i < int'(4'd1 << sz));
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] store_rep(input logic [DW-1:0] d, input logic [1:0] sz);
        logic [DW-1:0] r;
        case (sz)
            2'd0:    r = {BW{d[7:0]}};
            2'd1:    r = {(DW/16){d[15:0]}};
            2'd2:    r = {(DW/32){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // d is already shifted so the addressed lane sits at bit 0
    function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] d, input logic [1:0] sz,
                                               input logic uns);
        logic [DW-1:0] r;
        logic          sgn;
        int            nbits;
        nbits = 8 << sz;
        case (sz)
            2'd0:    sgn = d[7];
            2'd1:    sgn = d[15];
            2'd2:    sgn = d[31];
            default: sgn = d[DW-1];
        endcase
        for (int i = 0; i < DW; i++) begin
            if (i >= nbits) begin
                r[i] = uns ? 1'b0 : sgn;
            end else begin
                r[i] = d[i];
            end
        end
        return r;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [OB-1:0]   off_q, off_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [BW-1:0]   be_q, be_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rd_q, rd_d;
    logic            rd_write_q, rd_write_d;
    logic            bus_err_q, bus_err_d;
    logic            mis_q, mis_d;

    logic [AW-1:0]   ea_s;
    logic [AW-1:0]   bus_addr_s;
    logic [1:0]      eff_size_s;
    logic [OB-1:0]   mask_s;
    logic [OB-1:0]   off_al_s;
    logic            req_misal_s;
    logic [16:0]     cnt_inc_s;
    logic [DW-1:0]   rdata_sh_s;

    assign ea_s        = AW'(i_rs1) + AW'(signed'(i_imm));
    assign bus_addr_s  = {ea_s[AW-1:OB], {OB{1'b0}}};
    assign eff_size_s  = ((DW == 32) && (i_size == 2'd3)) ? 2'd2 : i_size;
    assign mask_s      = size_mask(eff_size_s);
    assign req_misal_s = |(ea_s[OB-1:0] & mask_s);
    assign off_al_s    = ea_s[OB-1:0] & ~mask_s;
    assign cnt_inc_s   = {1'b0, cnt_q} + 17'd1;
    assign rdata_sh_s  = i_r_lsu_data >> {off_q, 3'b000};

    // Next-state: accept in IDLE, then wait for ack (wins over timeout) or the timeout limit
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        read_d     = read_q;
        write_d    = write_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        rd_write_d = 1'b0;
        bus_err_d  = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid && !i_stall) begin
                    if (TRAP_EN && req_misal_s) begin
                        mis_d = 1'b1;
                    end else begin
                        size_d  = eff_size_s;
                        uns_d   = i_unsigned;
                        off_d   = off_al_s;
                        cnt_d   = 16'd0;
                        raddr_d = bus_addr_s;
                        waddr_d = bus_addr_s;
                        if (i_store) begin
                            write_d = 1'b1;
                            state_d = S_WR;
                            be_d    = be_base(eff_size_s) << off_al_s;
                            wdata_d = store_rep(i_rs2, eff_size_s);
                        end else begin
                            read_d  = 1'b1;
                            state_d = S_RD;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD, S_WR: begin
                if (i_lsu_ack) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = S_IDLE;
                    if (state_q == S_RD) begin
                        rd_d       = load_ext(rdata_sh_s, size_q, uns_q);
                        rd_write_d = 1'b1;
                    end else begin
                        rd_write_d = 1'b0;
                    end
                end else if (cnt_inc_s == TO_L) begin
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s[15:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // Registers advance only with i_clk_en; reset overrides the enable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rd_write_q <= 1'b0;
            bus_err_q  <= 1'b0;
            mis_q      <= 1'b0;
        end else if (i_clk_en) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            read_q     <= read_d;
            write_q    <= write_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rd_write_q <= rd_write_d;
            bus_err_q  <= bus_err_d;
            mis_q      <= mis_d;
        end
    end

    assign o_busy          = (state_q != S_IDLE);
    assign o_rd_write      = rd_write_q;
    assign o_rd            = rd_q;
    assign o_misaligned    = mis_q;
    assign o_bus_err       = bus_err_q;
    assign o_lsu_read      = read_q;
    assign o_r_lsu_addr    = raddr_q;
    assign o_lsu_write     = write_q;
    assign o_w_lsu_addr    = waddr_q;
    assign o_w_lsu_byte_en = be_q;
    assign o_w_lsu_data    = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (DW=32, TIMEOUT=4); load results are checked through a scoreboard queue.
module tb_lsu_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            i_rst, i_clk_en, i_stall, i_valid, i_store, i_unsigned, i_lsu_ack;
    logic [1:0]      i_size;
    logic [DW-1:0]   i_rs1, i_rs2, i_r_lsu_data;
    logic [31:0]     i_imm;
    logic            o_busy, o_rd_write, o_misaligned, o_bus_err, o_lsu_read, o_lsu_write;
    logic [DW-1:0]   o_rd, o_w_lsu_data;
    logic [AW-1:0]   o_r_lsu_addr, o_w_lsu_addr;
    logic [DW/8-1:0] o_w_lsu_byte_en;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rdw    = 0;
    int exp_rdw  = 0;
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    lsu_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_stall(i_stall),
        .i_valid(i_valid), .i_store(i_store), .i_size(i_size), .i_unsigned(i_unsigned),
        .i_rs1(i_rs1), .i_imm(i_imm), .i_rs2(i_rs2),
        .o_busy(o_busy), .o_rd_write(o_rd_write), .o_rd(o_rd),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .o_lsu_read(o_lsu_read), .o_r_lsu_addr(o_r_lsu_addr),
        .i_r_lsu_data(i_r_lsu_data), .i_lsu_ack(i_lsu_ack),
        .o_lsu_write(o_lsu_write), .o_w_lsu_addr(o_w_lsu_addr),
        .o_w_lsu_byte_en(o_w_lsu_byte_en), .o_w_lsu_data(o_w_lsu_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for the acceptance edge, then scramble inputs to prove capture
    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2);
        i_valid = 1'b1; i_store = st; i_size = sz; i_unsigned = uns;
        i_rs1 = rs1; i_imm = imm; i_rs2 = rs2;
        step();
        i_valid = 1'b0; i_size = 2'($urandom); i_unsigned = 1'($urandom);
        i_rs1 = $urandom; i_imm = $urandom; i_rs2 = $urandom;
    endtask

    task automatic expect_load(input logic [DW-1:0] v);
        sb.push_back(v);
        exp_rdw++;
    endtask

    always @(negedge clk) begin
        if (o_rd_write) begin
            n_rdw++;
            if (sb.size() > 0) chk("rd_data", o_rd, sb.pop_front());
            else chk("rd_unexpected", o_rd_write, 1'b0);
        end
    end

    initial begin
        i_rst = 1'b1; i_clk_en = 1'b1; i_stall = 1'b0; i_valid = 1'b0; i_store = 1'b0;
        i_size = 2'd0; i_unsigned = 1'b0; i_rs1 = '0; i_imm = '0; i_rs2 = '0;
        i_r_lsu_data = '0; i_lsu_ack = 1'b0;
        step(); step();
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_read", o_lsu_read, 1'b0);
        chk("rst_write", o_lsu_write, 1'b0);
        chk("rst_rd", o_rd, 32'h0);
        chk("rst_be", o_w_lsu_byte_en, 4'h0);
        i_rst = 1'b0;

        // load byte, signed, ack after 2 cycles
        expect_load(32'hFFFF_FF80);
        issue(1'b0, 2'd0, 1'b0, 32'h1000, 32'h3, 32'h0);
        chk("lb_read", o_lsu_read, 1'b1);
        chk("lb_busy", o_busy, 1'b1);
        chk("lb_addr", o_r_lsu_addr, 32'h1000);
        step();
        chk("lb_read_w1", o_lsu_read, 1'b1);
        i_lsu_ack = 1'b1; i_r_lsu_data = 32'h80FF_0000;
        step();
        i_lsu_ack = 1'b0; i_r_lsu_data = 32'h0;
        chk("lb_read_drop", o_lsu_read, 1'b0);
        chk("lb_rdw", o_rd_write, 1'b1);
        step();
        chk("lb_rdw_pulse", o_rd_write, 1'b0);
        chk("lb_idle", o_busy, 1'b0);
        chk("lb_rd_hold", o_rd, 32'hFFFF_FF80);

        // load half unsigned, ack immediately
        expect_load(32'h0000_8001);
        issue(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 32'h0);
        chk("lhu_addr", o_r_lsu_addr, 32'h1000);
        i_lsu_ack = 1'b1; i_r_lsu_data = 32'h8001_1234;
        step();
        i_lsu_ack = 1'b0;
        step();

        // load word with negative offset
        expect_load(32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h1008, 32'hFFFF_FFFC, 32'h0);
        chk("lw_addr", o_r_lsu_addr, 32'h1004);
        i_lsu_ack = 1'b1; i_r_lsu_data = 32'hDEAD_BEEF;
        step();
        i_lsu_ack = 1'b0;
        step();

        // address wraps modulo 2^AW
        expect_load(32'hFFFF_9ABC);
        issue(1'b0, 2'd1, 1'b0, 32'h2, 32'hFFFF_FFFC, 32'h0);
        chk("wrap_addr", o_r_lsu_addr, 32'hFFFF_FFFC);
        i_lsu_ack = 1'b1; i_r_lsu_data = 32'h9ABC_0000;
        step();
        i_lsu_ack = 1'b0;
        step();

        // store half, ack immediately
        issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h1234_ABCD);
        chk("sh_write", o_lsu_write, 1'b1);
        chk("sh_addr", o_w_lsu_addr, 32'h2000);
        chk("sh_be", o_w_lsu_byte_en, 4'b1100);
        chk("sh_data", o_w_lsu_data, 32'hABCD_ABCD);
        i_lsu_ack = 1'b1;
        step();
        i_lsu_ack = 1'b0;
        chk("sh_write_drop", o_lsu_write, 1'b0);
        chk("sh_no_rdw", o_rd_write, 1'b0);
        step();
        chk("sh_idle", o_busy, 1'b0);

        // store byte and size=3 (word on DW=32)
        issue(1'b1, 2'd0, 1'b0, 32'h3001, 32'h0, 32'hFFFF_FF55);
        chk("sb_be", o_w_lsu_byte_en, 4'b0010);
        chk("sb_data", o_w_lsu_data, 32'h5555_5555);
        i_lsu_ack = 1'b1; step(); i_lsu_ack = 1'b0; step();
        issue(1'b1, 2'd3, 1'b0, 32'h3000, 32'h4, 32'hDEAD_BEEF);
        chk("sd_addr", o_w_lsu_addr, 32'h3004);
        chk("sd_be", o_w_lsu_byte_en, 4'b1111);
        chk("sd_data", o_w_lsu_data, 32'hDEAD_BEEF);
        i_lsu_ack = 1'b1; step(); i_lsu_ack = 1'b0; step();

        // timeout: read high TO cycles, then bus_err pulse; late ack ignored
        issue(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0);
        for (int i = 0; i < TO; i++) begin
            chk($sformatf("to_read_%0d", i), o_lsu_read, 1'b1);
            chk($sformatf("to_noerr_%0d", i), o_bus_err, 1'b0);
            step();
        end
        chk("to_read_drop", o_lsu_read, 1'b0);
        chk("to_bus_err", o_bus_err, 1'b1);
        chk("to_idle", o_busy, 1'b0);
        i_lsu_ack = 1'b1;
        step();
        i_lsu_ack = 1'b0;
        chk("to_err_pulse", o_bus_err, 1'b0);
        chk("to_late_ack", o_rd_write, 1'b0);
        chk("to_late_busy", o_busy, 1'b0);

        // ack on the timeout cycle wins
        expect_load(32'h1357_2468);
        issue(1'b0, 2'd2, 1'b0, 32'h4100, 32'h0, 32'h0);
        step(); step(); step();
        i_lsu_ack = 1'b1; i_r_lsu_data = 32'h1357_2468;
        step();
        i_lsu_ack = 1'b0;
        chk("race_no_err", o_bus_err, 1'b0);
        chk("race_rdw", o_rd_write, 1'b1);
        step();

        // misaligned word load at 0x1001
        issue(1'b0, 2'd2, 1'b0, 32'h1001, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_pulse", o_misaligned, 1'b1);
        chk("mis_no_read", o_lsu_read, 1'b0);
        chk("mis_idle", o_busy, 1'b0);
        step();
        chk("mis_pulse_end", o_misaligned, 1'b0);
        chk("mis_still_no_read", o_lsu_read, 1'b0);
`else
        chk("mis_tied0", o_misaligned, 1'b0);
        chk("mis_read", o_lsu_read, 1'b1);
        chk("mis_addr", o_r_lsu_addr, 32'h1000);
        expect_load(32'h1122_3344);
        i_lsu_ack = 1'b1; i_r_lsu_data = 32'h1122_3344;
        step();
        i_lsu_ack = 1'b0;
        step();
`endif

        // clock enable low mid-wait with ack: nothing completes until re-enabled
        expect_load(32'hCAFE_F00D);
        issue(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'h0);
        i_clk_en = 1'b0; i_lsu_ack = 1'b1; i_r_lsu_data = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) i_lsu_ack = 1'b0;
            step();
            chk($sformatf("ce_hold_read_%0d", i), o_lsu_read, 1'b1);
            chk($sformatf("ce_hold_rdw_%0d", i), o_rd_write, 1'b0);
        end
        i_clk_en = 1'b1; i_lsu_ack = 1'b1;
        step();
        i_lsu_ack = 1'b0;
        chk("ce_rdw", o_rd_write, 1'b1);
        chk("ce_idle", o_busy, 1'b0);
        step();
        chk("ce_rdw_pulse", o_rd_write, 1'b0);

        // reset during WR_WAIT clears everything; following ack ignored
        issue(1'b1, 2'd2, 1'b0, 32'h6000, 32'h0, 32'hA5A5_A5A5);
        chk("rw_write", o_lsu_write, 1'b1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("rw_write_drop", o_lsu_write, 1'b0);
        chk("rw_busy", o_busy, 1'b0);
        chk("rw_waddr", o_w_lsu_addr, 32'h0);
        chk("rw_wdata", o_w_lsu_data, 32'h0);
        chk("rw_raddr", o_r_lsu_addr, 32'h0);
        chk("rw_rd", o_rd, 32'h0);
        i_lsu_ack = 1'b1;
        step();
        i_lsu_ack = 1'b0;
        chk("rw_ack_ignored", o_rd_write, 1'b0);

        // stall and disabled clock block acceptance
        i_stall = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 32'h0);
        chk("stall_busy", o_busy, 1'b0);
        chk("stall_read", o_lsu_read, 1'b0);
        i_stall = 1'b0; i_clk_en = 1'b0;
        issue(1'b1, 2'd2, 1'b0, 32'h7000, 32'h0, 32'h0);
        chk("ce_busy", o_busy, 1'b0);
        chk("ce_write", o_lsu_write, 1'b0);
        i_clk_en = 1'b1;
        step(); step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("rdw_count", 64'(n_rdw), 64'(exp_rdw));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
